// File: rtl/text_vram_arbiter.sv
// rtl/text_vram_arbiter.sv - char RAM arbiter: display fetch slots win, CPU gets req/ack access in between
module text_vram_arbiter #(
   parameter int COLS        = 80,
   parameter int ROWS        = 30,
   parameter int FETCH_PHASE = 0,
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [9:0]        dot_counter_i,
   input  logic [8:0]        scanline_counter_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_ack_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [DATA_W-1:0] char_code_o,
   output logic              char_valid_o
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

   localparam logic [2:0]      PHASE = 3'(FETCH_PHASE);
   localparam logic [ADDR_W:0] CELLS = (ADDR_W+1)'(COLS * ROWS);

   state_e            state_q, state_d;
   logic              fetch_q;
   logic              char_valid_q;
   logic [DATA_W-1:0] char_code_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic              rd_ok_q, rd_ok_d;

   logic              slot;
   logic              grant;
   logic              in_range;
   logic [4:0]        row;
   logic [6:0]        col;
   logic [ADDR_W-1:0] disp_addr;

   assign slot     = (dot_counter_i[2:0] == PHASE);
   assign in_range = ({1'b0, cpu_addr_i} < CELLS);
   assign row      = scanline_counter_i[8:4];
   assign col      = dot_counter_i[9:3];
   // row*80 built from two shifts
   assign disp_addr = ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);

   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = disp_addr;
      ram_wdata_o = '0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req_i && !slot) begin
               grant   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT:  state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      rd_ok_d = grant && !cpu_we_i && in_range;
      if (slot) begin
         ram_en_o = 1'b1;
      end else if (grant) begin
         ram_en_o    = in_range;
         ram_we_o    = cpu_we_i && in_range;
         ram_addr_o  = cpu_addr_i;
         ram_wdata_o = cpu_wdata_i;
      end
      // RAM stays quiet for the whole time reset is held
      if (!rst_n_i) begin
         ram_en_o    = 1'b0;
         ram_we_o    = 1'b0;
         ram_addr_o  = '0;
         ram_wdata_o = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         fetch_q      <= 1'b0;
         char_valid_q <= 1'b0;
         char_code_q  <= '0;
         cpu_rdata_q  <= '0;
         rd_ok_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_q      <= slot;
         char_valid_q <= fetch_q;
         rd_ok_q      <= rd_ok_d;
         if (fetch_q) begin
            char_code_q <= ram_rdata_i;
         end
         if (state_q == S_WAIT) begin
            cpu_rdata_q <= rd_ok_q ? ram_rdata_i : '0;
         end
      end
   end

   assign cpu_ack_o    = (state_q == S_ACK);
   assign cpu_rdata_o  = cpu_rdata_q;
   assign char_code_o  = char_code_q;
   assign char_valid_o = char_valid_q;

endmodule

// File: tb/tb_text_vram_arbiter.sv
// tb/tb_text_vram_arbiter.sv - directed bench for text_vram_arbiter with a behavioural char RAM
module tb_text_vram_arbiter;

   logic        clk;
   logic        rst_n;
   logic [9:0]  dot;
   logic [8:0]  sl;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  char_code;
   logic        char_valid;

   logic [7:0]  mem [0:4095];
   int          vectors;
   int          miscompares;
   int          acks;
   logic        prev_ack;

   text_vram_arbiter dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .dot_counter_i      (dot),
      .scanline_counter_i (sl),
      .cpu_req_i          (cpu_req),
      .cpu_we_i           (cpu_we),
      .cpu_addr_i         (cpu_addr),
      .cpu_wdata_i        (cpu_wdata),
      .cpu_ack_o          (cpu_ack),
      .cpu_rdata_o        (cpu_rdata),
      .ram_en_o           (ram_en),
      .ram_we_o           (ram_we),
      .ram_addr_o         (ram_addr),
      .ram_wdata_o        (ram_wdata),
      .ram_rdata_i        (ram_rdata),
      .char_code_o        (char_code),
      .char_valid_o       (char_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   initial begin
      ram_rdata  <= 8'h00;
      mem[0]     <= 8'h33;
      mem[5]     <= 8'h11;
      mem[81]    <= 8'h41;
      mem[2399]  <= 8'h5A;
      mem[2400]  <= 8'h00;
      mem[4095]  <= 8'hAA;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (dot == 10'd639) begin
         dot = 10'd0;
         sl  = (sl == 9'd479) ? 9'd0 : sl + 9'd1;
      end else begin
         dot = dot + 10'd1;
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; acks = 0; prev_ack = 1'b0;
      rst_n = 1'b1; dot = 10'd3; sl = 9'd7;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'd0; cpu_wdata = 8'd0;
      #2 rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // display fetch of cell 81, two clocks of latency
      dot = 10'd8; sl = 9'd16;
      #1;
      chk("disp81_en", ram_en, 1);
      chk("disp81_we", ram_we, 0);
      chk("disp81_addr", ram_addr, 81);
      chk("disp81_valid_t", char_valid, 0);
      tick(); #1;
      chk("disp81_valid_t1", char_valid, 0);
      tick(); #1;
      chk("disp81_valid_t2", char_valid, 1);
      chk("disp81_code", char_code, 8'h41);

      // start a CPU read, then reset it away in WAIT
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd81;
      #1;
      chk("pre_rst_grant_en", ram_en, 1);
      chk("pre_rst_grant_addr", ram_addr, 81);
      tick();
      rst_n = 1'b0;
      #1;
      chk("rst_ack", cpu_ack, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_code", char_code, 0);
      chk("rst_valid", char_valid, 0);
      chk("rst_en", ram_en, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      cpu_req = 1'b0;
      tick();
      rst_n = 1'b1; dot = 10'd0; sl = 9'd0;
      #1;
      chk("post_rst_slot_en", ram_en, 1);
      chk("post_rst_slot_addr", ram_addr, 0);
      tick(); #1;
      chk("post_rst_no_ack", cpu_ack, 0);
      tick(); #1;
      chk("post_rst_no_ack2", cpu_ack, 0);
      chk("post_rst_valid", char_valid, 1);
      chk("post_rst_code", char_code, 8'h33);

      // CPU write raised on a slot: deferred one cycle
      tick();
      dot = 10'd16; sl = 9'd0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd5; cpu_wdata = 8'h7E;
      #1;
      chk("wr5_slot_en", ram_en, 1);
      chk("wr5_slot_we", ram_we, 0);
      chk("wr5_slot_addr", ram_addr, 2);
      tick(); #1;
      chk("wr5_grant_en", ram_en, 1);
      chk("wr5_grant_we", ram_we, 1);
      chk("wr5_grant_addr", ram_addr, 5);
      chk("wr5_grant_wdata", ram_wdata, 8'h7E);
      tick(); #1;
      chk("wr5_wait_en", ram_en, 0);
      chk("wr5_wait_ack", cpu_ack, 0);
      tick(); #1;
      chk("wr5_ack", cpu_ack, 1);
      tick();
      cpu_req = 1'b0;
      #1;
      chk("wr5_ack_drop", cpu_ack, 0);
      tick();
      dot = 10'd40; sl = 9'd0;
      #1;
      chk("fetch5_addr", ram_addr, 5);
      tick(); tick(); #1;
      chk("fetch5_valid", char_valid, 1);
      chk("fetch5_code", char_code, 8'h7E);

      // CPU read of the last cell on a non-slot cycle
      tick();
      dot = 10'd41; sl = 9'd0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd2399;
      #1;
      chk("rd2399_en", ram_en, 1);
      chk("rd2399_we", ram_we, 0);
      chk("rd2399_addr", ram_addr, 2399);
      tick(); #1;
      chk("rd2399_wait_ack", cpu_ack, 0);
      tick(); #1;
      chk("rd2399_ack", cpu_ack, 1);
      chk("rd2399_rdata", cpu_rdata, 8'h5A);
      tick();
      cpu_req = 1'b0;

      // out-of-range write and read
      tick();
      dot = 10'd49; sl = 9'd0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd2400; cpu_wdata = 8'hFF;
      #1;
      chk("wr2400_en", ram_en, 0);
      chk("wr2400_we", ram_we, 0);
      tick(); tick(); #1;
      chk("wr2400_ack", cpu_ack, 1);
      tick();
      cpu_req = 1'b0;
      tick();
      dot = 10'd57; sl = 9'd0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd4095;
      #1;
      chk("rd4095_en", ram_en, 0);
      tick(); tick(); #1;
      chk("rd4095_ack", cpu_ack, 1);
      chk("rd4095_rdata", cpu_rdata, 0);
      tick();
      cpu_req = 1'b0;

      // frame wrap, then a full line of back-to-back CPU reads
      tick();
      dot = 10'd639; sl = 9'd479;
      #1;
      chk("wrap_last_en", ram_en, 0);
      tick();
      for (int i = 0; i < 640; i++) begin
         cpu_req = !prev_ack; cpu_we = 1'b0; cpu_addr = 12'd100;
         #1;
         if (dot[2:0] == 3'd0) begin
            chk("line_slot_en", ram_en, 1);
            chk("line_slot_we", ram_we, 0);
            chk("line_slot_addr", ram_addr, sl[8:4] * 80 + dot[9:3]);
         end
         prev_ack = cpu_ack;
         if (cpu_ack) acks++;
         tick();
      end
      chk("line_acks", acks, 160);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
